// File: rtl/pdm_audio_axil_regs.sv
// pdm_audio_axil_regs: AXI4-Lite register block for the PDM audio core.
//   ACLK/ARESET  : clock, synchronous active-high reset
//   S_AXI_*      : AXI4-Lite slave port (CTRL, CLKDIV, TXDATA, RXDATA, STATUS)
//   ctrl_*       : CTRL[2:0] enables; clk_div: CLKDIV[15:0]
//   tx_*         : sample stream to the core (valid/ready)
//   rx_*         : sample strobe from the core
//   irq          : only when PDM_AXIL_IRQ_EN is defined (CTRL[3] = irq_en)
module pdm_audio_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            ctrl_en,
  output logic                            ctrl_tx_en,
  output logic                            ctrl_rx_en,
  output logic [15:0]                     clk_div,
  output logic [SAMPLE_WIDTH-1:0]         tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [SAMPLE_WIDTH-1:0]         rx_data,
  input  logic                            rx_valid
`ifdef PDM_AXIL_IRQ_EN
  ,
  output logic                            irq
`endif
);
`ifdef PDM_AXIL_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif
  logic ready_q, aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, wa;
  logic [31:0] wdata_q, wd, txreg, rx_ext, status, rd_next;
  logic [3:0] wstrb_q, ws, ctrl;
  logic [2:0] widx, ridx;
  logic aw_fire, w_fire, ar_fire, wr, wr_err, rx_clr;
  logic [SAMPLE_WIDTH-1:0] rxreg;
  logic rx_avail, tx_ovr, rx_ovr;
  logic unused_ok;
  // ready_q keeps every READY low during reset and for the first edge after it
  assign S_AXI_AWREADY = ready_q && !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY = ready_q && !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = ready_q && !S_AXI_RVALID;
  assign ctrl_en = ctrl[0];
  assign ctrl_tx_en = ctrl[1];
  assign ctrl_rx_en = ctrl[2];
  assign tx_data = txreg[SAMPLE_WIDTH-1:0];
  always_comb begin
    aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    w_fire = S_AXI_WVALID && S_AXI_WREADY;
    ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    // a channel handshaking this cycle counts as held, so the write commits on that edge
    wa = aw_held ? aw_addr_q : S_AXI_AWADDR;
    wd = w_held ? wdata_q : S_AXI_WDATA;
    ws = w_held ? wstrb_q : S_AXI_WSTRB;
    widx = wa[4:2];
    ridx = S_AXI_ARADDR[4:2];
    wr = (aw_held || aw_fire) && (w_held || w_fire) && !S_AXI_BVALID;
    wr_err = widx > 3'd4 || (widx == 3'd2 && tx_valid);
    rx_clr = ar_fire && ridx == 3'd3;
    rx_ext = '0;
    rx_ext[SAMPLE_WIDTH-1:0] = rxreg;
    status = {28'd0, rx_ovr, tx_ovr, rx_avail, tx_valid};
    rd_next = ridx == 3'd0 ? {28'd0, ctrl} :
              ridx == 3'd1 ? {16'd0, clk_div} :
              ridx == 3'd2 ? txreg :
              ridx == 3'd3 ? rx_ext :
              ridx == 3'd4 ? status : 32'd0;
    unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wa[1:0], S_AXI_ARADDR[1:0]};
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_q <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
      ctrl <= '0;
      clk_div <= 16'd50;
      txreg <= '0;
      tx_valid <= 1'b0;
      rxreg <= '0;
      rx_avail <= 1'b0;
      tx_ovr <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      if (wr) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= wr_err ? 2'b10 : 2'b00;
      end
      if (wr && widx == 3'd0 && ws[0]) ctrl <= wd[3:0] & CTRL_MASK;
      if (wr && widx == 3'd1 && ws[0]) clk_div[7:0] <= wd[7:0];
      if (wr && widx == 3'd1 && ws[1]) clk_div[15:8] <= wd[15:8];
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      // STATUS clears come before the sets below so a same-edge event wins
      if (wr && widx == 3'd4 && ws[0] && wd[2]) tx_ovr <= 1'b0;
      if (wr && widx == 3'd4 && ws[0] && wd[3]) rx_ovr <= 1'b0;
      if (wr && widx == 3'd2 && tx_valid) tx_ovr <= 1'b1;
      if (wr && widx == 3'd2 && !tx_valid) begin
        tx_valid <= 1'b1;
        for (int i = 0; i < 4; i++) if (ws[i]) txreg[8*i +: 8] <= wd[8*i +: 8];
      end
      // a sample arriving alongside an RXDATA read keeps rx_avail set and is not an overrun
      if (rx_valid) begin
        rxreg <= rx_data;
        rx_avail <= 1'b1;
        if (rx_avail && !rx_clr) rx_ovr <= 1'b1;
      end else if (rx_clr) begin
        rx_avail <= 1'b0;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (ar_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA <= rd_next;
        S_AXI_RRESP <= ridx > 3'd4 ? 2'b10 : 2'b00;
      end
    end
  end
`ifdef PDM_AXIL_IRQ_EN
  always_ff @(posedge ACLK) irq <= ARESET ? 1'b0 : ctrl[3] && (rx_avail || rx_ovr || tx_ovr);
`endif
endmodule

// File: tb/tb_pdm_audio_axil_regs.sv
// tb_pdm_audio_axil_regs: scoreboard bench for pdm_audio_axil_regs with a register-level reference model
module tb_pdm_audio_axil_regs;
  localparam int SW = 16;
`ifdef PDM_AXIL_IRQ_EN
  localparam logic [3:0] CMASK = 4'hF;
  logic irq;
`else
  localparam logic [3:0] CMASK = 4'h7;
`endif
  logic ACLK = 1'b0, ARESET;
  logic [4:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic ctrl_en, ctrl_tx_en, ctrl_rx_en, tx_valid, tx_ready, rx_valid;
  logic [15:0] clk_div;
  logic [SW-1:0] tx_data, rx_data;
  int vectors = 0, miscompares = 0, txv_cnt = 0;
  logic [SW-1:0] last_tx;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  logic [3:0] m_ctrl;
  logic [15:0] m_clkdiv;
  logic [31:0] m_tx;
  logic [SW-1:0] m_rx;
  logic m_txv, m_avail, m_txovr, m_rxovr;

  pdm_audio_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_en(ctrl_en), .ctrl_tx_en(ctrl_tx_en), .ctrl_rx_en(ctrl_rx_en), .clk_div(clk_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef PDM_AXIL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the expected response whenever a B or R handshake is about to complete
  always @(negedge ACLK) begin
    if (S_AXI_BVALID === 1'b1 && S_AXI_BREADY === 1'b1) begin
      if (bq.size() == 0) chk("b_unexpected", 64'(S_AXI_BRESP), 64'hDEAD);
      else chk("bresp", 64'(S_AXI_BRESP), 64'(bq.pop_front()));
    end
    if (S_AXI_RVALID === 1'b1 && S_AXI_RREADY === 1'b1) begin
      if (rq.size() == 0) chk("r_unexpected", 64'({S_AXI_RRESP, S_AXI_RDATA}), 64'hDEAD);
      else chk("read_resp_data", 64'({S_AXI_RRESP, S_AXI_RDATA}), 64'(rq.pop_front()));
    end
    if (tx_valid === 1'b1) begin
      txv_cnt++;
      last_tx = tx_data;
    end
  end

  task automatic m_reset;
    m_ctrl = 0; m_clkdiv = 16'd50; m_tx = 0; m_rx = 0;
    m_txv = 0; m_avail = 0; m_txovr = 0; m_rxovr = 0;
  endtask

  task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    r = 2'b00;
    case (a[4:2])
      3'd0: if (s[0]) m_ctrl = d[3:0] & CMASK;
      3'd1: begin
        if (s[0]) m_clkdiv[7:0] = d[7:0];
        if (s[1]) m_clkdiv[15:8] = d[15:8];
      end
      3'd2: if (m_txv) begin
        m_txovr = 1;
        r = 2'b10;
      end else begin
        for (int i = 0; i < 4; i++) if (s[i]) m_tx[8*i +: 8] = d[8*i +: 8];
        m_txv = 1;
      end
      3'd3: ;
      3'd4: if (s[0]) begin
        if (d[2]) m_txovr = 0;
        if (d[3]) m_rxovr = 0;
      end
      default: r = 2'b10;
    endcase
  endtask

  task automatic m_read(input logic [4:0] a, output logic [33:0] e);
    case (a[4:2])
      3'd0: e = {2'b00, 28'd0, m_ctrl};
      3'd1: e = {2'b00, 16'd0, m_clkdiv};
      3'd2: e = {2'b00, m_tx};
      3'd3: e = {2'b00, 16'd0, m_rx};
      3'd4: e = {2'b00, 28'd0, m_rxovr, m_txovr, m_avail, m_txv};
      default: e = {2'b10, 32'd0};
    endcase
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle;
    repeat (2) tick();
    rx_data = SW'($urandom);
    if (tx_ready) m_txv = 0;
  endtask

  task automatic check_outputs;
    chk("ctrl_en", 64'(ctrl_en), 64'(m_ctrl[0]));
    chk("ctrl_tx_en", 64'(ctrl_tx_en), 64'(m_ctrl[1]));
    chk("ctrl_rx_en", 64'(ctrl_rx_en), 64'(m_ctrl[2]));
    chk("clk_div", 64'(clk_div), 64'(m_clkdiv));
    chk("tx_valid", 64'(tx_valid), 64'(m_txv));
    chk("tx_data", 64'(tx_data), 64'(m_tx[SW-1:0]));
`ifdef PDM_AXIL_IRQ_EN
    chk("irq", 64'(irq), 64'(m_ctrl[3] && (m_avail || m_rxovr || m_txovr)));
`endif
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int ad, input int wdl);
    logic [1:0] r;
    int cyc;
    bit aw_done, w_done;
    m_write(a, d, s, r);
    bq.push_back(r);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= ad) begin S_AXI_AWVALID = 1; S_AXI_AWADDR = a; end
      if (!w_done && cyc >= wdl) begin S_AXI_WVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s; end
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      tick();
      if (aw_done) S_AXI_AWVALID = 0;
      if (w_done) S_AXI_WVALID = 0;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      chk("aw_w_handshake_timeout", 64'({aw_done, w_done}), 64'h3);
      S_AXI_AWVALID = 0;
      S_AXI_WVALID = 0;
    end else begin
      @(negedge ACLK);
      chk("b_latency", 64'(S_AXI_BVALID), 64'h1);
    end
    tick();
    settle();
  endtask

  task automatic axi_read(input logic [4:0] a, input bit rxv, input logic [SW-1:0] rxd);
    logic [33:0] e;
    int cyc;
    bit done;
    m_read(a, e);
    rq.push_back(e);
    if (rxv) begin
      m_rx = rxd;
      m_avail = 1;
    end else if (a[4:2] == 3'd3) m_avail = 0;
    S_AXI_ARVALID = 1; S_AXI_ARADDR = a;
    if (rxv) begin rx_valid = 1; rx_data = rxd; end
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge ACLK);
      if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1;
      tick();
      rx_valid = 0;
      if (done) S_AXI_ARVALID = 0;
      cyc++;
    end
    if (!done) begin
      chk("ar_handshake_timeout", 64'(done), 64'h1);
      S_AXI_ARVALID = 0;
    end else begin
      @(negedge ACLK);
      chk("r_latency", 64'(S_AXI_RVALID), 64'h1);
    end
    tick();
    settle();
  endtask

  task automatic rx_pulse(input logic [SW-1:0] d);
    rx_valid = 1; rx_data = d;
    tick();
    rx_valid = 0;
    if (m_avail) m_rxovr = 1;
    m_avail = 1;
    m_rx = d;
    settle();
  endtask

  initial begin
    int c0, op;
    logic [4:0] a;
    ARESET = 1; tx_ready = 1; rx_valid = 0; rx_data = 0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0; S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    S_AXI_AWADDR = 0; S_AXI_ARADDR = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
    S_AXI_AWPROT = 3'd0; S_AXI_ARPROT = 3'd0;
    m_reset();
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_awready", 64'(S_AXI_AWREADY), 64'h0);
    chk("rst_arready", 64'(S_AXI_ARREADY), 64'h0);
    chk("rst_bvalid", 64'(S_AXI_BVALID), 64'h0);
    chk("rst_rvalid", 64'(S_AXI_RVALID), 64'h0);
    check_outputs();
    tick();
    ARESET = 0;
    @(negedge ACLK);
    chk("ready_held_low", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h0);
    tick();
    @(negedge ACLK);
    chk("ready_after_reset", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);
    tick();
    // basic writes and readback, TX handed to a ready core
    axi_write(5'h00, 32'h1, 4'hF, 0, 0);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0);
    c0 = txv_cnt;
    axi_write(5'h08, 32'h3, 4'hF, 0, 0);
    chk("tx_valid_cycles", 64'(txv_cnt - c0), 64'h1);
    chk("tx_data_sent", 64'(last_tx), 64'h3);
    axi_read(5'h00, 0, 0);
    axi_read(5'h04, 0, 0);
    axi_read(5'h08, 0, 0);
    chk("ctrl_en_set", 64'(ctrl_en), 64'h1);
    chk("clk_div_2", 64'(clk_div), 64'h2);
    check_outputs();
    // AW and W in both orders with partial strobes
    axi_write(5'h04, 32'hABCD1234, 4'b0011, 0, 3);
    axi_write(5'h04, 32'hABCD1234, 4'b0011, 2, 0);
    chk("clk_div_1234", 64'(clk_div), 64'h1234);
    // TX overrun
    tx_ready = 0;
    settle();
    axi_write(5'h08, 32'h55, 4'hF, 0, 0);
    axi_write(5'h08, 32'h66, 4'hF, 1, 0);
    chk("tx_data_kept", 64'(tx_data), 64'h55);
    axi_read(5'h10, 0, 0);
    axi_write(5'h10, 32'h4, 4'h1, 0, 0);
    axi_read(5'h10, 0, 0);
    tx_ready = 1;
    settle();
    check_outputs();
    // RX overrun and read-to-clear
    rx_pulse(16'h0102);
    rx_pulse(16'h0304);
    axi_read(5'h10, 0, 0);
    axi_read(5'h0C, 0, 0);
    axi_read(5'h10, 0, 0);
    // RXDATA read coinciding with a new sample
    axi_write(5'h10, 32'hC, 4'h1, 0, 0);
    rx_pulse(16'h1111);
    axi_read(5'h0D, 1, 16'h2222);
    axi_read(5'h12, 0, 0);
    axi_read(5'h0C, 0, 0);
    // unmapped accesses and ignored writes
    axi_read(5'h18, 0, 0);
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(5'h0C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_read(5'h0C, 0, 0);
    check_outputs();
`ifdef PDM_AXIL_IRQ_EN
    axi_write(5'h00, 32'h8, 4'hF, 0, 0);
    rx_valid = 1; rx_data = 16'h0AA0;
    tick();
    rx_valid = 0;
    m_avail = 1; m_rx = 16'h0AA0;
    @(negedge ACLK);
    chk("irq_latency_low", 64'(irq), 64'h0);
    tick();
    @(negedge ACLK);
    chk("irq_high", 64'(irq), 64'h1);
    tick();
    settle();
    axi_read(5'h0C, 0, 0);
    chk("irq_cleared", 64'(irq), 64'h0);
`endif
    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (op < 4) axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op < 7) axi_read(a, 0, 0);
      else if (op < 9) rx_pulse(SW'($urandom));
      else begin
        tx_ready = 1'($urandom_range(0, 1));
        settle();
      end
      check_outputs();
    end
    // reset while a write response is pending
    tx_ready = 0;
    settle();
    axi_write(5'h08, 32'h77, 4'hF, 0, 0);
    S_AXI_BREADY = 0;
    axi_write(5'h00, 32'h7, 4'hF, 0, 0);
    chk("b_pending", 64'(S_AXI_BVALID), 64'h1);
    ARESET = 1;
    tick();
    ARESET = 0;
    @(negedge ACLK);
    chk("rst_bvalid_drop", 64'(S_AXI_BVALID), 64'h0);
    chk("rst_ready_low", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h0);
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_clk_div", 64'(clk_div), 64'd50);
    tick();
    @(negedge ACLK);
    chk("rst_ready_high", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);
    bq.delete();
    S_AXI_BREADY = 1;
    m_reset();
    tx_ready = 1;
    tick();
    for (int i = 0; i < 5; i++) axi_read(5'(i * 4), 0, 0);
    check_outputs();
    repeat (4) tick();
    chk("bq_drained", 64'(bq.size()), 64'h0);
    chk("rq_drained", 64'(rq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pdm_audio_axil_regs.md
Name: pdm_audio_axil_regs

Overview:
AXI4-Lite responder (slave) for the PDM audio IP; it answers the transactions issued by the AXI4-Lite master agent in the block design.
- Holds the control and configuration registers.
- Hands TX samples to the PDM core over a valid/ready stream.
- Latches RX samples from the core and exposes status flags.
- Sits between the AXI interconnect port S00_AXI and the PDM modulator/demodulator core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses bits [4:2]
SAMPLE_WIDTH, 16, PCM sample width (1..32)

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; synchronous, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
ctrl_en, ctrl_tx_en, ctrl_rx_en  out  1 each  CTRL[0], CTRL[1], CTRL[2]
clk_div  out  16  CLKDIV[15:0]
tx_data  out  SAMPLE_WIDTH  sample to core
tx_valid  out  1  sample pending
tx_ready  in  1  core accepts sample
rx_data  in  SAMPLE_WIDTH  sample from core
rx_valid  in  1  one-cycle strobe, rx_data valid
irq  out  1  present only with PDM_AXIL_IRQ_EN

Behaviour:
Register map:
- 0x00 CTRL: RW, bits [3:0], reset 0.
- 0x04 CLKDIV: RW, bits [15:0], reset 16'd50.
- 0x08 TXDATA: RW, holds the last written value, reset 0.
- 0x0C RXDATA: RO, zero-extended, reset 0.
- 0x10 STATUS: bit0 tx_busy (=tx_valid), bit1 rx_avail, bit2 tx_ovr, bit3 rx_ovr. Bits 2 and 3 are sticky, write-1-to-clear.
- 0x14–0x1C: unmapped.
- Address bits [1:0] are ignored. Write strobes apply per byte to CTRL, CLKDIV and TXDATA.

Write channel:
- AW and W are captured independently, in either order or in the same cycle.
- AWREADY is high while no AW is held and BVALID=0; WREADY is high while no W is held and BVALID=0.
- Once both are held, the register updates on the next edge and BVALID rises on that same edge. Latency is 1 cycle after the later handshake.
- BVALID holds until BREADY; the held AW/W are released at the B handshake.
- Only one write is outstanding at a time.

Read channel:
- ARREADY = !RVALID.
- RDATA/RRESP are registered and RVALID rises 1 cycle after the AR handshake, holding until RREADY.
- Read and write channels run concurrently and independently.

TX path:
- A write to TXDATA while tx_valid=0 loads tx_data from WDATA[SAMPLE_WIDTH-1:0] and sets tx_valid. BRESP=OKAY.
- tx_valid clears on the edge where tx_valid && tx_ready.
- A write to TXDATA while tx_valid=1 returns BRESP=SLVERR; tx_data is unchanged and tx_ovr is set.

RX path:
- rx_valid latches rx_data into RXDATA and sets rx_avail. If rx_avail was already 1, rx_ovr is also set.
- An AR handshake on RXDATA clears rx_avail.
- If rx_valid and that AR handshake fall in the same cycle: the read returns the old value, the new sample is latched, rx_avail stays 1, rx_ovr is unchanged.

Unmapped addresses:
- Writes have no effect and return SLVERR.
- Reads return RDATA=0 with SLVERR.

Other register accesses:
- Writes to RXDATA are ignored and return OKAY.
- A write to STATUS only clears bits 2/3 where WDATA bit=1 and WSTRB[0]=1.

Reset:
- ARESET clears all registers and outputs to their reset values on the next edge, including AWREADY/WREADY/ARREADY/BVALID/RVALID/tx_valid = 0.
- In-flight transactions are discarded.
- All READY signals go high one cycle after ARESET deasserts.

Optional Feature:
PDM_AXIL_IRQ_EN:
- When defined: CTRL[3] becomes irq_en, and the irq port exists. irq is registered, irq = CTRL[3] && (rx_avail || rx_ovr || tx_ovr), with 1-cycle latency.
- When undefined: the irq port is absent, CTRL[3] reads 0 and ignores writes.

Test Plan:
- Writes 0x00←0x1, 0x04←0x2, 0x08←0x3 (core tx_ready=1) -> all BRESP=00; readback returns 0x1, 0x2, 0x3; ctrl_en=1, clk_div=2; tx_data=3 for exactly one tx_valid cycle.
- AW presented 3 cycles before W, then W presented 2 cycles before AW, both to CLKDIV with WSTRB=0011 and data 0xABCD1234 -> each BVALID 1 cycle after the later handshake; CLKDIV=0x1234.
- tx_ready=0, write TXDATA←0x55 then TXDATA←0x66 -> second write BRESP=10; tx_data stays 0x55; STATUS=0x5. Writing STATUS←0x4 -> STATUS=0x1.
- rx_valid with 0x0102, then rx_valid with 0x0304 -> STATUS bit3=1; reading RXDATA returns 0x304 and clears bit1.
- Read of 0x18 -> RDATA=0, RRESP=10. Assert ARESET while BVALID=1 with BREADY=0 -> BVALID=0 next cycle and all registers at reset values.
- With PDM_AXIL_IRQ_EN: CTRL←0x8, then rx_valid -> irq=1 one cycle later; reading RXDATA -> irq=0.
